// File: rtl/ucie_ctl_sb_arbiter_if.sv
// Request/issue bundle between the CNTL-side requesters and the sideband
// arbiter. Requesters drive the master side; the arbiter is the slave.
interface ucie_ctl_sb_arbiter_if;
  // Handshake: a requester raises i_req[k] and holds its decode/data stable
  // until it sees o_ack[k]. o_ack[k] is a one-cycle pulse that always
  // coincides with o_sb_lp_valid, and the issued decode/payload are the values
  // captured at grant time. Dropping i_req[k] before the grant withdraws the
  // request. i_sb_busy_flag is the sideband's back-pressure; the arbiter never
  // grants while it is high.
  logic [2:0]  i_req;
  logic [14:0] i_req_decode;
  logic [95:0] i_req_data;
  logic [2:0]  o_ack;
  logic        i_sb_busy_flag;
  logic        o_sb_lp_valid;
  logic [4:0]  o_sb_lp_decode;
  logic [31:0] o_sb_lp_adv_cap_val;
  logic        o_timeout;
  logic [1:0]  dbg_state;

  modport master (
    output i_req, i_req_decode, i_req_data, i_sb_busy_flag,
    input  o_ack, o_sb_lp_valid, o_sb_lp_decode, o_sb_lp_adv_cap_val,
    input  o_timeout, dbg_state
  );

  modport slave (
    input  i_req, i_req_decode, i_req_data, i_sb_busy_flag,
    output o_ack, o_sb_lp_valid, o_sb_lp_decode, o_sb_lp_adv_cap_val,
    output o_timeout, dbg_state
  );
endinterface

// File: rtl/ucie_ctl_sb_arbiter.sv
// Round-robin arbiter that serialises three CNTL message sources onto the
// sideband transmitter, tracking its busy flag and timing out a stuck sideband.
module ucie_ctl_sb_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  ucie_ctl_sb_arbiter_if.slave   sb
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  grant;
  logic [15:0] cnt;

  logic [2:0]  req_rot;
  logic [1:0]  win;
  logic [4:0]  win_decode;
  logic [31:0] win_data;
  logic        grant_ok;

  function automatic logic [1:0] next_idx(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // req_rot[i] is the request of requester (ptr+i) mod 3, so bit 0 has priority.
  always_comb begin
    req_rot = sb.i_req;
    case (ptr)
      2'd1:    req_rot = {sb.i_req[0], sb.i_req[2], sb.i_req[1]};
      2'd2:    req_rot = {sb.i_req[1], sb.i_req[0], sb.i_req[2]};
      default: req_rot = sb.i_req;
    endcase
  end

  always_comb begin
    win = next_idx(next_idx(ptr));
    if (req_rot[0]) begin
      win = ptr;
    end else if (req_rot[1]) begin
      win = next_idx(ptr);
    end
  end

  always_comb begin
    win_decode = sb.i_req_decode[4:0];
    win_data   = sb.i_req_data[31:0];
    case (win)
      2'd1: begin
        win_decode = sb.i_req_decode[9:5];
        win_data   = sb.i_req_data[63:32];
      end
      2'd2: begin
        win_decode = sb.i_req_decode[14:10];
        win_data   = sb.i_req_data[95:64];
      end
      default: begin
        win_decode = sb.i_req_decode[4:0];
        win_data   = sb.i_req_data[31:0];
      end
    endcase
  end

  assign grant_ok = (|sb.i_req) && !sb.i_sb_busy_flag;

  // Outputs are registered: the grant edge loads valid/ack/decode/payload
  // together, so the ISSUE cycle is exactly the cycle the message is visible.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state                  <= IDLE;
      ptr                    <= 2'd0;
      grant                  <= 2'd0;
      cnt                    <= 16'd0;
      sb.o_sb_lp_valid       <= 1'b0;
      sb.o_ack               <= 3'b000;
      sb.o_timeout           <= 1'b0;
      sb.o_sb_lp_decode      <= 5'd0;
      sb.o_sb_lp_adv_cap_val <= 32'd0;
    end else begin
      sb.o_sb_lp_valid <= 1'b0;
      sb.o_ack         <= 3'b000;
      sb.o_timeout     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_ok) begin
            grant                  <= win;
            sb.o_sb_lp_decode      <= win_decode;
            sb.o_sb_lp_adv_cap_val <= win_data;
            sb.o_sb_lp_valid       <= 1'b1;
            sb.o_ack               <= 3'b001 << win;
            state                  <= ISSUE;
          end
        end
        ISSUE: begin
          ptr   <= next_idx(grant);
          cnt   <= 16'd0;
          state <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // No busy in the cycle after issue means the sideband took it.
          if (sb.i_sb_busy_flag) begin
            cnt   <= 16'd0;
            state <= WAIT_DONE;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_DONE: begin
          if (!sb.i_sb_busy_flag) begin
            state <= IDLE;
          end else if (cnt >= CNT_LAST) begin
            sb.o_timeout <= 1'b1;
            state        <= IDLE;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sb.dbg_state = state;

endmodule

// File: tb/tb_ucie_ctl_sb_arbiter.sv
// Directed and randomized checks of the sideband arbiter against a
// transaction-level model: rotating priority pointer plus a per-message timeline.
module tb_ucie_ctl_sb_arbiter;
  localparam int T = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ucie_ctl_sb_arbiter_if sb_if ();

  ucie_ctl_sb_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .sb      (sb_if)
  );

  int checks = 0;
  int errors = 0;

  // Model: next-search start, and the message last put on the sideband.
  int          m_ptr;
  logic [4:0]  m_dec;
  logic [31:0] m_data;
  logic [39:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r);
    for (int i = 0; i < 3; i++) begin
      if (r[(m_ptr + i) % 3]) return (m_ptr + i) % 3;
    end
    return -1;
  endfunction

  task automatic set_req(input logic [2:0] r);
    sb_if.i_req        = r;
    sb_if.i_req_decode = 15'($urandom);
    sb_if.i_req_data   = {$urandom, $urandom, $urandom};
  endtask

  task automatic check_quiet(input string tag, input logic to);
    chk({tag, "_valid"}, 40'(sb_if.o_sb_lp_valid), 40'd0);
    chk({tag, "_ack"}, 40'(sb_if.o_ack), 40'd0);
    chk({tag, "_timeout"}, 40'(sb_if.o_timeout), 40'(to));
    chk({tag, "_hold"}, {3'd0, sb_if.o_sb_lp_decode, sb_if.o_sb_lp_adv_cap_val},
        {3'd0, m_dec, m_data});
  endtask

  // Called in an IDLE cycle with busy low and a request pending.
  task automatic expect_issue(input string tag, input bit keep);
    int w;
    logic [2:0] a;
    w = pick(sb_if.i_req);
    if (w < 0) w = 0;
    a      = 3'(1 << w);
    m_dec  = sb_if.i_req_decode[w*5 +: 5];
    m_data = sb_if.i_req_data[w*32 +: 32];
    exp_q.push_back({a, m_dec, m_data});
    m_ptr = (w + 1) % 3;
    step();
    chk({tag, "_valid"}, 40'(sb_if.o_sb_lp_valid), 40'd1);
    chk({tag, "_timeout"}, 40'(sb_if.o_timeout), 40'd0);
    chk({tag, "_msg"}, {sb_if.o_ack, sb_if.o_sb_lp_decode, sb_if.o_sb_lp_adv_cap_val},
        exp_q.pop_front());
    // Post-grant input changes must not leak into the issued message.
    if (!keep) sb_if.i_req[w] = 1'b0;
    sb_if.i_req_decode = 15'($urandom);
    sb_if.i_req_data   = {$urandom, $urandom, $urandom};
  endtask

  // Called in the ISSUE cycle. busy is high for k cycles starting with the
  // cycle after issue; k > T means the sideband is stuck and must time out.
  // Returns in the first IDLE cycle.
  task automatic complete(input string tag, input int k);
    int last;
    last = (k >= T + 1) ? T + 2 : k + 2;
    sb_if.i_sb_busy_flag = (k > 0);
    step();
    check_quiet({tag, "_wb"}, 1'b0);
    sb_if.i_sb_busy_flag = (k >= 1);
    if (k == 0) begin
      step();
      check_quiet({tag, "_fast"}, 1'b0);
    end else begin
      for (int j = 2; j <= last; j++) begin
        step();
        check_quiet({tag, "_wd"}, (k >= T + 1) && (j == last));
        if (j < last) begin
          sb_if.i_sb_busy_flag = (j <= k);
          sb_if.i_req = sb_if.i_req | 3'($urandom);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sb_if.i_req          = 3'b000;
    sb_if.i_req_decode   = 15'd0;
    sb_if.i_req_data     = 96'd0;
    sb_if.i_sb_busy_flag = 1'b0;
    m_ptr  = 0;
    m_dec  = 5'd0;
    m_data = 32'd0;

    // Reset state
    #2;
    check_quiet("reset", 1'b0);
    step();
    step();
    rst_n = 1'b1;

    // Single request from requester 0
    sb_if.i_req        = 3'b001;
    sb_if.i_req_decode = 15'h000A;
    sb_if.i_req_data   = 96'h1234;
    expect_issue("single", 1'b0);
    chk("single_dec", 40'(sb_if.o_sb_lp_decode), 40'h0A);
    chk("single_data", 40'(sb_if.o_sb_lp_adv_cap_val), 40'h1234);
    complete("single", 0);

    // Round robin with all three held; pointer starts at 1 here
    set_req(3'b111);
    expect_issue("rr1", 1'b1);
    chk("rr1_ack", 40'(sb_if.o_ack), 40'h2);
    complete("rr1", 0);
    expect_issue("rr2", 1'b1);
    chk("rr2_ack", 40'(sb_if.o_ack), 40'h4);
    complete("rr2", 0);
    expect_issue("rr3", 1'b1);
    chk("rr3_ack", 40'(sb_if.o_ack), 40'h1);
    complete("rr3", 0);
    expect_issue("rr4", 1'b1);
    chk("rr4_ack", 40'(sb_if.o_ack), 40'h2);

    // Busy handshake of 5 cycles
    complete("busy5", 5);
    set_req(3'b101);
    expect_issue("after_busy", 1'b0);

    // Busy held for exactly T cycles: boundary, no timeout
    complete("busyT", T);
    expect_issue("after_busyT", 1'b0);

    // Stuck busy: one timeout pulse, then blocked in IDLE
    complete("stuck", T + 1);
    set_req(3'b111);
    for (int i = 0; i < 4; i++) begin
      step();
      check_quiet("blocked", 1'b0);
    end
    sb_if.i_sb_busy_flag = 1'b0;
    expect_issue("unblocked", 1'b0);

    // Fast accept with another request pending: 3-cycle spacing
    complete("fast", 0);
    set_req(3'b011);
    expect_issue("fast_a", 1'b0);
    complete("fast_a", 0);
    expect_issue("fast_b", 1'b0);

    // Reset in the middle of WAIT_DONE
    sb_if.i_sb_busy_flag = 1'b1;
    step();
    step();
    step();
    #3;
    rst_n = 1'b0;
    m_ptr  = 0;
    m_dec  = 5'd0;
    m_data = 32'd0;
    #1;
    check_quiet("async_rst", 1'b0);
    step();
    check_quiet("in_rst", 1'b0);
    rst_n = 1'b1;
    sb_if.i_sb_busy_flag = 1'b0;
    set_req(3'b100);
    expect_issue("post_rst", 1'b0);
    chk("post_rst_ack", 40'(sb_if.o_ack), 40'h4);
    complete("post_rst", 0);

    // Randomized traffic
    for (int n = 0; n < 150; n++) begin
      int idle_n;
      int k;
      idle_n = $urandom_range(0, 2);
      for (int i = 0; i < idle_n; i++) begin
        sb_if.i_sb_busy_flag = 1'($urandom_range(0, 1));
        sb_if.i_req = sb_if.i_sb_busy_flag ? 3'($urandom) : 3'b000;
        step();
        check_quiet("rnd_idle", 1'b0);
      end
      sb_if.i_sb_busy_flag = 1'b0;
      set_req(3'($urandom_range(1, 7)));
      expect_issue("rnd", 1'($urandom_range(0, 1)));
      k = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, T + 1);
      complete("rnd", k);
    end

    chk("exp_q_empty", 40'(exp_q.size()), 40'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
